// File: rtl/alu_seq_pkg.sv
// Shared opcode values, FSM state encoding and LED decode for the sequential ALU card.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NOTB = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns {done, rdy, wait, idle}; exactly one bit set for every state.
    function automatic logic [3:0] led_decode(input state_t s);
        logic [3:0] leds;
        case (s)
            ST_IDLE:  leds = 4'b0001;
            ST_LOAD:  leds = 4'b0010;
            ST_READY: leds = 4'b0100;
            ST_DONE:  leds = 4'b1000;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// Combinational ALU function f(opcode, A, B); saturating ADD/SUB when ALU_SAT_EN is defined.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_n,
    output logic             cout_n,
    output logic             borrow_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit holds carry for the sum and goes high on A<B for the difference.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_n = '0;
        cout_n   = 1'b0;
        borrow_n = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_n = sum[WIDTH-1:0];
                cout_n   = sum[WIDTH];
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) result_n = '1;
`endif
            end
            OP_SUB: begin
                result_n = diff[WIDTH-1:0];
                borrow_n = diff[WIDTH];
`ifdef ALU_SAT_EN
                if (diff[WIDTH]) result_n = '0;
`endif
            end
            OP_NOTA: result_n = ~a;
            OP_NOTB: result_n = ~b;
            OP_AND:  result_n = a & b;
            OP_OR:   result_n = a | b;
            OP_XOR:  result_n = a ^ b;
            default: result_n = ~(a ^ b);
        endcase
    end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: go-edge handshake FSM, operand/result registers and status LEDs.
// Build option: define ALU_SAT_EN for saturating ADD/SUB.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             borrow,
    output logic             zero,
    output logic             led_idle,
    output logic             led_wait,
    output logic             led_rdy,
    output logic             led_done
);

    state_t           state_q, state_d;
    logic             go_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] result_n;
    logic             cout_n;
    logic             borrow_n;
    logic             rise;
    logic             fall;

    assign rise = go & ~go_q;
    assign fall = ~go & go_q;

    alu_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .opcode   (opcode),
        .a        (a_q),
        .b        (b_q),
        .result_n (result_n),
        .cout_n   (cout_n),
        .borrow_n (borrow_n)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rise) begin
                    a_d     = data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (fall) begin
                    b_d     = data;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // The only state where opcode reaches the output registers.
                result_d = result_n;
                cout_d   = cout_n;
                borrow_d = borrow_n;
                zero_d   = (result_n == '0);
                state_d  = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            go_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            go_q     <= go;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign {led_done, led_rdy, led_wait, led_idle} = led_decode(state_q);

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core against an arithmetic reference model.
module tb_alu_seq_core;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         go;
    logic [W-1:0] data;
    logic [2:0]   opcode;
    logic [W-1:0] result;
    logic         cout;
    logic         borrow;
    logic         zero;
    logic         led_idle;
    logic         led_wait;
    logic         led_rdy;
    logic         led_done;
    logic [3:0]   leds;

    int total = 0;
    int bad   = 0;

    alu_seq_core #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .data     (data),
        .opcode   (opcode),
        .result   (result),
        .cout     (cout),
        .borrow   (borrow),
        .zero     (zero),
        .led_idle (led_idle),
        .led_wait (led_wait),
        .led_rdy  (led_rdy),
        .led_done (led_done)
    );

    assign leds = {led_done, led_rdy, led_wait, led_idle};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {result, cout, borrow, zero} from plain integer arithmetic.
    function automatic logic [W+2:0] ref_alu(input int a, input int b, input int op);
        int m;
        int v;
        logic c;
        logic bw;
        m  = 1 << W;
        c  = 1'b0;
        bw = 1'b0;
        case (op)
            0: begin
                v = a + b;
                c = (v >= m);
                v = v % m;
`ifdef ALU_SAT_EN
                if (c) v = m - 1;
`endif
            end
            1: begin
                bw = (a < b);
                v  = (a - b + m) % m;
`ifdef ALU_SAT_EN
                if (bw) v = 0;
`endif
            end
            2: v = m - 1 - a;
            3: v = m - 1 - b;
            4: v = a & b;
            5: v = a | b;
            6: v = a ^ b;
            default: v = m - 1 - (a ^ b);
        endcase
        return {W'(v), c, bw, (v == 0)};
    endfunction

    // Drives one full rise/fall handshake from IDLE or DONE, sampling LEDs in LOAD, READY and DONE.
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input int hold, output logic [11:0] led_seq);
        @(negedge clk);
        data   = a;
        go     = 1'b1;
        opcode = 3'($urandom_range(0, 7));
        @(negedge clk);
        led_seq[11:8] = leds;
        for (int i = 0; i < hold; i++) begin
            data = W'($urandom);
            @(negedge clk);
        end
        data   = b;
        go     = 1'b0;
        opcode = op;
        @(negedge clk);
        led_seq[7:4] = leds;
        data = W'($urandom);
        @(negedge clk);
        led_seq[3:0] = leds;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        go     = 1'b0;
        data   = '0;
        opcode = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({leds, result, cout, borrow, zero} !== {4'b0001, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_values: got leds=%b res=%0h c=%b b=%b z=%b, want leds=0001 res=0 c=0 b=0 z=1",
                     leds, result, cout, borrow, zero);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (leds !== 4'b0001) begin
            bad++;
            $display("FAIL idle_after_reset: got leds=%b want 0001", leds);
        end
    endtask

    task automatic test_vectors();
        logic [11:0]  seq;
        logic [W+2:0] exp;
        int va[8];
        int vb[8];
        int vo[8];
        va = '{9, 3, 10, 10, 10, 10, 10, 15};
        vb = '{8, 5, 6, 6, 6, 6, 6, 1};
        vo = '{0, 1, 2, 3, 4, 5, 6, 0};
        for (int i = 0; i < 9; i++) begin
            int k;
            k = (i < 8) ? i : 4;
            if (i == 8) begin
                va[k] = 10; vb[k] = 6; vo[k] = 7;
            end
            do_txn(W'(va[k]), W'(vb[k]), 3'(vo[k]), (i == 0) ? 2 : i % 3, seq);
            exp = ref_alu(va[k], vb[k], vo[k]);
            total++;
            if (seq !== 12'b0010_0100_1000) begin
                bad++;
                $display("FAIL vec%0d_leds: got %b want 001001001000", i, seq);
            end
            total++;
            if ({result, cout, borrow, zero} !== exp) begin
                bad++;
                $display("FAIL vec%0d_out: A=%0h B=%0h op=%0d got res=%0h c=%b b=%b z=%b want %0h/%b/%b/%b",
                         i, va[k], vb[k], vo[k], result, cout, borrow, zero,
                         exp[W+2:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_done_hold();
        logic [11:0]  seq;
        logic [W+2:0] exp;
        do_txn(W'(7), W'(12), 3'd5, 1, seq);
        exp = ref_alu(7, 12, 5);
        for (int i = 0; i < 6; i++) begin
            opcode = 3'($urandom_range(0, 7));
            data   = W'($urandom);
            @(negedge clk);
            total++;
            if ({leds, result, cout, borrow, zero} !== {4'b1000, exp}) begin
                bad++;
                $display("FAIL done_hold%0d: got leds=%b res=%0h want leds=1000 res=%0h", i, leds, result, exp[W+2:3]);
            end
        end
        do_txn(W'(1), W'(1), 3'd4, 0, seq);
        exp = ref_alu(1, 1, 4);
        total++;
        if ({seq, result, cout, borrow, zero} !== {12'b0010_0100_1000, exp}) begin
            bad++;
            $display("FAIL done_restart: got seq=%b res=%0h want res=%0h", seq, result, exp[W+2:3]);
        end
    endtask

    task automatic test_ignore_rise();
        logic [W+2:0] exp;
        exp = ref_alu(5, 9, 1);
        @(negedge clk);
        data = W'(5);
        go   = 1'b1;
        @(negedge clk);
        data   = W'(9);
        go     = 1'b0;
        opcode = 3'd1;
        @(negedge clk);
        go   = 1'b1;
        data = W'(3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({leds, result, cout, borrow, zero} !== {4'b1000, exp}) begin
                bad++;
                $display("FAIL ignore_rise%0d: got leds=%b res=%0h b=%b want leds=1000 res=%0h b=%b",
                         i, leds, result, borrow, exp[W+2:3], exp[1]);
            end
            if (i == 1) go = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0]  seq;
        logic [W+2:0] exp;
        @(negedge clk);
        data = W'(13);
        go   = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({leds, result, cout, borrow, zero} !== {4'b0001, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: got leds=%b res=%0h z=%b want leds=0001 res=0 z=1", leds, result, zero);
        end
        go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_txn(W'(2), W'(2), 3'd6, 1, seq);
        exp = ref_alu(2, 2, 6);
        total++;
        if ({seq, result, cout, borrow, zero} !== {12'b0010_0100_1000, exp}) begin
            bad++;
            $display("FAIL after_reset_txn: got seq=%b res=%0h z=%b want res=%0h z=%b",
                     seq, result, zero, exp[W+2:3], exp[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0]  seq;
        logic [W+2:0] exp;
        int a;
        int b;
        int op;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom_range(0, (1 << W) - 1);
            b  = $urandom_range(0, (1 << W) - 1);
            op = $urandom_range(0, 7);
            do_txn(W'(a), W'(b), 3'(op), $urandom_range(0, 2), seq);
            exp = ref_alu(a, b, op);
            total++;
            if ({seq, result, cout, borrow, zero} !== {12'b0010_0100_1000, exp}) begin
                bad++;
                $display("FAIL rand%0d: A=%0h B=%0h op=%0d got seq=%b res=%0h c=%b b=%b z=%b want %0h/%b/%b/%b",
                         i, a, b, op, seq, result, cout, borrow, zero,
                         exp[W+2:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_done_hold();
        test_ignore_rise();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
